// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Instruction-fetch sequencer between the CPU and a byte-wide instruction
//   memory. Each request reads the four bytes at PC..PC+3, one byte per
//   acknowledged memory cycle, and assembles them little-endian into a
//   32-bit word. The CPU is stalled with BUSYWAIT while the fetch runs.
//
//   Optional feature macro: FETCH_HIT_EN
//     When defined, a one-entry tag remembers the base of the last completed
//     fetch. A repeat request for that address completes without touching
//     memory. A fault or reset invalidates the tag.
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous reset, active low
//   PC           byte address of the requested instruction
//   FETCH_REQ    CPU requests the word at PC
//   INSTRUCTION  last fetched word {b3,b2,b1,b0}, b0 from address PC
//   INSTR_VALID  one-cycle pulse, fetch complete / INSTRUCTION updated
//   INSTR_FAULT  one-cycle pulse, misaligned / out-of-range PC or ack timeout
//   BUSYWAIT     CPU stall
//   IMEM_ADDR    byte address to memory
//   IMEM_READ    read strobe, held until the byte is acknowledged
//   IMEM_RDATA   read data, valid with IMEM_ACK
//   IMEM_ACK     memory acknowledges the current byte
module instr_fetch_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter int          MEM_BYTES = 1024,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] RST_INSTR = 32'h0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       PC,
  input  logic              FETCH_REQ,
  output logic [31:0]       INSTRUCTION,
  output logic              INSTR_VALID,
  output logic              INSTR_FAULT,
  output logic              BUSYWAIT,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic              IMEM_READ,
  input  logic [7:0]        IMEM_RDATA,
  input  logic              IMEM_ACK
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, FAULT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        byte_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [2:0][7:0]   lanes;     // bytes 0..2; byte 3 goes straight to INSTRUCTION
  logic [32:0]       last_addr;
  logic              bad_pc;
  logic              hit;

  // One extra bit so a PC near 2^32 cannot wrap into range.
  assign last_addr = {1'b0, PC} + 33'd3;
  assign bad_pc    = (PC[1:0] != 2'b00) || (last_addr >= 33'(MEM_BYTES));

`ifdef FETCH_HIT_EN
  logic [ADDR_W-1:0] tag;
  logic              tag_vld;

  assign hit = tag_vld && (PC == 32'(tag));

  // The tag is written in the DONE/FAULT cycle so it is already current in
  // the IDLE cycle that follows. base still holds the completed address.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tag     <= '0;
      tag_vld <= 1'b0;
    end else if (INSTR_FAULT) begin
      tag_vld <= 1'b0;
    end else if (INSTR_VALID) begin
      tag     <= base;
      tag_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Counter wraps inside the 4-byte window; no carry past ADDR_W.
  assign IMEM_ADDR = base + ADDR_W'(byte_cnt);

  // Combinational in IDLE so the CPU stalls in the very cycle it requests.
  // Gated by RESET so every output is quiet while reset is held.
  assign BUSYWAIT = RESET && ((state == FETCH) ||
                              (state == IDLE && FETCH_REQ && !hit));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      base        <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      lanes       <= '0;
      INSTRUCTION <= RST_INSTR;
      INSTR_VALID <= 1'b0;
      INSTR_FAULT <= 1'b0;
      IMEM_READ   <= 1'b0;
    end else begin
      INSTR_VALID <= 1'b0;
      INSTR_FAULT <= 1'b0;
      case (state)
        IDLE: begin
          if (FETCH_REQ) begin
            if (bad_pc) begin
              state       <= FAULT;
              INSTR_FAULT <= 1'b1;
            end else if (hit) begin
              state       <= DONE;
              INSTR_VALID <= 1'b1;
            end else begin
              state     <= FETCH;
              base      <= PC[ADDR_W-1:0];
              byte_cnt  <= '0;
              tmo_cnt   <= '0;
              IMEM_READ <= 1'b1;
            end
          end
        end
        FETCH: begin
          // An ack on the last timeout cycle still wins over the fault.
          if (IMEM_ACK) begin
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= '0;
            for (int i = 0; i < 3; i++)
              if (byte_cnt == 2'(i)) lanes[i] <= IMEM_RDATA;
            if (byte_cnt == 2'd3) begin
              INSTRUCTION <= {IMEM_RDATA, lanes[2], lanes[1], lanes[0]};
              state       <= DONE;
              INSTR_VALID <= 1'b1;
              IMEM_READ   <= 1'b0;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Partial lanes are simply abandoned; INSTRUCTION is untouched.
            state       <= FAULT;
            INSTR_FAULT <= 1'b1;
            IMEM_READ   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a byte memory with programmable per-byte ack
// delay, a table of directed fetches, hand-written corner sequences, and a
// randomized phase checked against a request-level reference model.
module tb_instr_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic        FETCH_REQ;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID, INSTR_FAULT, BUSYWAIT, IMEM_READ;
  logic [9:0]  IMEM_ADDR;
  logic [7:0]  IMEM_RDATA = 8'h00;
  logic        IMEM_ACK   = 1'b0;

  instr_fetch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .FETCH_REQ(FETCH_REQ),
    .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_FAULT(INSTR_FAULT), .BUSYWAIT(BUSYWAIT),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_READ(IMEM_READ),
    .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  // waits[i] = idle cycles before byte i of the current fetch is acked.
  logic [7:0] mem [1024];
  int         waits [4];
  bit         spur_ack = 1'b0;
  int         ack_idx = 0, wcnt = 0;
  logic       read_prev = 1'b0;

  always @(negedge CLK) begin
    if (!IMEM_READ) begin
      ack_idx    = 0;
      wcnt       = 0;
      IMEM_ACK   = spur_ack;
      IMEM_RDATA = 8'($urandom);
    end else begin
      if (IMEM_ACK && read_prev) begin
        ack_idx++;
        wcnt = 0;
      end
      IMEM_ACK = (wcnt >= waits[ack_idx & 3]);
      if (!IMEM_ACK) wcnt++;
      IMEM_RDATA = mem[IMEM_ADDR];
    end
    read_prev = IMEM_READ;
  end

  task automatic set_waits(input int a, input int b, input int c, input int d);
    waits[0] = a; waits[1] = b; waits[2] = c; waits[3] = d;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_last   = 32'h0;
  bit          m_tag_v  = 1'b0;
  logic [31:0] m_tag_pc = 32'h0;

  // Outcome of one request: fault?, stall cycles after the request edge,
  // resulting word, tag hit?
  function automatic void predict(input logic [31:0] pc, output bit f, output int b,
                                  output logic [31:0] w, output bit h);
    longint end_addr;
    int     a;
    end_addr = longint'(pc) + 3;
    h = 1'b0;
`ifdef FETCH_HIT_EN
    h = m_tag_v && (m_tag_pc == pc);
`endif
    f = 1'b0;
    b = 0;
    w = m_last;
    if ((pc % 4) != 0 || end_addr >= 1024) begin
      f = 1'b1;
    end else if (!h) begin
      for (int i = 0; i < 4; i++) begin
        if (!f) begin
          if (waits[i] >= 16) begin
            f = 1'b1;
            b += 16;
          end else begin
            b += waits[i] + 1;
          end
        end
      end
      a = int'(pc);
      if (!f) w = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    end
  endfunction

  // Issue one request at the current sample point and check everything it
  // does. Leaves the bench at the sample point one cycle after the pulse.
  task automatic run_fetch(input logic [31:0] pc, input bit toggle, input bit exp_fault,
                           input int exp_busy, input logic [31:0] exp_word,
                           input bit exp_hit, input string nm);
    int cyc = 0, busy = 0, acks = 0;
    bit seen_read = 1'b0, addr_bad = 1'b0, got_v = 1'b0, got_f = 1'b0;
    logic [31:0] want;
    PC = pc;
    FETCH_REQ = 1'b1;
    #1;
    check({nm, ".stall_req"}, 32'(BUSYWAIT), 32'(!exp_hit));
    while (!(got_v || got_f) && cyc < 400) begin
      @(negedge CLK); #3;
      cyc++;
      if (IMEM_READ) begin
        seen_read = 1'b1;
        if (IMEM_ADDR != 10'(pc + 32'(acks))) addr_bad = 1'b1;
        if (IMEM_ACK) acks++;
      end
      if (BUSYWAIT) busy++;
      got_v = INSTR_VALID;
      got_f = INSTR_FAULT;
      if (cyc == 1) FETCH_REQ = 1'b0;
      if (toggle && cyc == 2) PC = pc + 32'd4;
    end
    check({nm, ".finished"}, 32'(got_v | got_f), 32'd1);
    check({nm, ".valid"}, 32'(got_v), 32'(!exp_fault));
    check({nm, ".fault"}, 32'(got_f), 32'(exp_fault));
    check({nm, ".busy"}, 32'(busy), 32'(exp_busy));
    check({nm, ".latency"}, 32'(cyc), 32'(exp_busy + 1));
    check({nm, ".mem_read"}, 32'(seen_read), 32'(exp_busy > 0));
    check({nm, ".addr_seq"}, 32'(addr_bad), 32'd0);
    want = exp_fault ? m_last : exp_word;
    check({nm, ".instr"}, INSTRUCTION, want);
    @(negedge CLK); #3;
    check({nm, ".pulse_end"}, 32'({INSTR_VALID, INSTR_FAULT, IMEM_READ}), 32'd0);
    if (exp_fault) begin
      m_tag_v = 1'b0;
    end else begin
      m_last   = exp_word;
      m_tag_v  = 1'b1;
      m_tag_pc = pc;
    end
  endtask

  task automatic run_model(input logic [31:0] pc, input bit toggle, input string nm);
    bit f, h;
    int b;
    logic [31:0] w;
    predict(pc, f, b, w, h);
    run_fetch(pc, toggle, f, b, w, h, nm);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          w0, w1, w2, w3;
    bit          toggle;
    bit          exp_fault;
    int          exp_busy;
    logic [31:0] exp_word;
  } vec_t;

  initial begin
    vec_t vt [10];
    int n, v1, v2;
    logic gap_read;
    logic [31:0] w1;
    logic [31:0] pc;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h04; mem[3] = 8'h00;
    set_waits(0, 0, 0, 0);

    vt[0] = '{32'd0,          0, 0, 0, 0,   1'b0, 1'b0, 4,  32'h00040005};
    vt[1] = '{32'd8,          2, 2, 2, 2,   1'b1, 1'b0, 12, 32'h51505352};
    vt[2] = '{32'd6,          0, 0, 0, 0,   1'b0, 1'b1, 0,  32'h0};
    vt[3] = '{32'd1022,       0, 0, 0, 0,   1'b0, 1'b1, 0,  32'h0};
    vt[4] = '{32'd4,          16, 0, 0, 0,  1'b0, 1'b1, 16, 32'h0};
    vt[5] = '{32'd4,          15, 15, 15, 15, 1'b0, 1'b0, 64, 32'h5D5C5F5E};
    vt[6] = '{32'd1020,       0, 1, 0, 1,   1'b0, 1'b0, 6,  32'hA5A4A7A6};
    vt[7] = '{32'd1024,       0, 0, 0, 0,   1'b0, 1'b1, 0,  32'h0};
    vt[8] = '{32'hFFFFFFFC,   0, 0, 0, 0,   1'b0, 1'b1, 0,  32'h0};
    vt[9] = '{32'd12,         0, 3, 16, 0,  1'b0, 1'b1, 21, 32'h0};

    // reset state
    RESET = 1'b0; FETCH_REQ = 1'b0; PC = 32'h0;
    #3;
    check("rst.instr", INSTRUCTION, 32'h0);
    check("rst.outs", 32'({INSTR_VALID, INSTR_FAULT, BUSYWAIT, IMEM_READ}), 32'd0);
    check("rst.addr", 32'(IMEM_ADDR), 32'd0);
    @(negedge CLK); #3;
    RESET = 1'b1;

    // directed table
    for (int i = 0; i < 10; i++) begin
      set_waits(vt[i].w0, vt[i].w1, vt[i].w2, vt[i].w3);
      run_fetch(vt[i].pc, vt[i].toggle, vt[i].exp_fault, vt[i].exp_busy,
                vt[i].exp_word, 1'b0, $sformatf("vec%0d", i));
    end

    // acks while no read is outstanding are ignored
    spur_ack = 1'b1;
    gap_read = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); #3;
      gap_read = gap_read | IMEM_READ | INSTR_VALID | INSTR_FAULT;
    end
    check("spur.idle", 32'(gap_read), 32'd0);
    set_waits(1, 1, 1, 1);
    run_model(32'd8, 1'b0, "spur.fetch");
    spur_ack = 1'b0;

    // reset in the middle of a fetch
    set_waits(5, 5, 5, 5);
    PC = 32'd16; FETCH_REQ = 1'b1;
    for (int c = 0; c < 3; c++) begin @(negedge CLK); #3; end
    check("rstmid.reading", 32'(IMEM_READ), 32'd1);
    RESET = 1'b0;
    #1;
    check("rstmid.read", 32'(IMEM_READ), 32'd0);
    check("rstmid.busy", 32'(BUSYWAIT), 32'd0);
    check("rstmid.instr", INSTRUCTION, 32'h0);
    check("rstmid.addr", 32'(IMEM_ADDR), 32'd0);
    @(negedge CLK); #3;
    FETCH_REQ = 1'b0; RESET = 1'b1;
    m_last = 32'h0; m_tag_v = 1'b0;
    @(negedge CLK); #3;
    check("rstmid.idle", 32'({IMEM_READ, INSTR_VALID, INSTR_FAULT}), 32'd0);

    // back-to-back with the request held
    set_waits(0, 0, 0, 0);
    PC = 32'd0; FETCH_REQ = 1'b1;
    n = 0; v1 = 0; v2 = 0; gap_read = 1'b1; w1 = 32'h0;
    for (int c = 1; c <= 40 && n < 2; c++) begin
      @(negedge CLK); #3;
      if (n == 1 && c == v1 + 1) gap_read = IMEM_READ | INSTR_VALID;
      if (INSTR_VALID) begin
        n++;
        if (n == 1) begin v1 = c; w1 = INSTRUCTION; PC = 32'd4; end
        else begin v2 = c; FETCH_REQ = 1'b0; end
      end
    end
    check("b2b.count", 32'(n), 32'd2);
    check("b2b.first", w1, 32'h00040005);
    check("b2b.gap", 32'(gap_read), 32'd0);
    check("b2b.spacing", 32'(v2 - v1), 32'd6);
    check("b2b.second", INSTRUCTION, 32'h5D5C5F5E);
    m_last = 32'h5D5C5F5E; m_tag_v = 1'b1; m_tag_pc = 32'd4;
    @(negedge CLK); #3;

    // repeat / fault / refetch of the same address
    run_model(32'd4, 1'b0, "rep.first");
    run_model(32'd6, 1'b0, "rep.fault");
    run_model(32'd4, 1'b0, "rep.after_fault");

    // randomized requests against the model
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: begin pc = $urandom; if (pc[1:0] == 2'b00) pc[0] = 1'b1; end
        1: pc = 32'd1020 + 32'd4 * 32'($urandom_range(0, 3));
        default: pc = 32'd4 * 32'($urandom_range(0, 7));
      endcase
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 11))
          0: waits[j] = 16 + int'($urandom_range(0, 2));
          1: waits[j] = 15;
          default: waits[j] = int'($urandom_range(0, 3));
        endcase
      end
      run_model(pc, $urandom_range(0, 3) == 0, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
